// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scan driver: per-frame input snapshot,
// common-anode digit enables, per-digit blank and blink.
module display_scanner #(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_SCANS = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*DIGITS-1:0]   codes,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  output logic [DIGITS-1:0]     an,
  output logic [4:0]            code,
  output logic                  frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [PW-1:0]     pcnt_reg;
  logic [SW-1:0]     sel_reg;
  logic [BW-1:0]     bcnt_reg;
  logic              phase_reg;
  logic [4:0]        shadow_code_reg [DIGITS];
  logic [DIGITS-1:0] shadow_blank_reg;
  logic [DIGITS-1:0] shadow_blink_reg;
  logic [4:0]        code_in [DIGITS];
  logic [DIGITS-1:0] an_next;
  logic              tick;
  logic              wrap;
  logic              dark;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_split
      assign code_in[gi] = codes[5*gi +: 5];
    end
  endgenerate

  assign tick = (pcnt_reg == PW'(SCAN_DIV - 1));
  assign wrap = tick && (sel_reg == SW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_reg <= '0;
      sel_reg  <= '0;
    end else begin
      pcnt_reg <= tick ? '0 : pcnt_reg + PW'(1);
      if (wrap)
        sel_reg <= '0;
      else if (tick)
        sel_reg <= sel_reg + SW'(1);
    end
  end

  // Inputs are only sampled on the frame wrap so a frame never shows torn digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++)
        shadow_code_reg[i] <= '0;
      shadow_blank_reg <= '1;
      shadow_blink_reg <= '0;
    end else if (wrap) begin
      for (int i = 0; i < DIGITS; i++)
        shadow_code_reg[i] <= code_in[i];
      shadow_blank_reg <= blank;
      shadow_blink_reg <= blink;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (wrap) begin
      if (bcnt_reg == BW'(BLINK_SCANS - 1)) begin
        bcnt_reg  <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        bcnt_reg <= bcnt_reg + BW'(1);
      end
    end
  end

  // Blank wins over blink; blink only darkens digits during phase 1.
  assign dark = shadow_blank_reg[sel_reg] | (shadow_blink_reg[sel_reg] & phase_reg);

  always_comb begin
    an_next = '1;
    if (!dark)
      an_next[sel_reg] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an    <= '1;
      code  <= '0;
      frame <= 1'b0;
    end else begin
      an    <= an_next;
      code  <= shadow_code_reg[sel_reg];
      frame <= wrap;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: reset, scan order, snapshot,
// blank/blink phases, code pass-through and mid-frame asynchronous reset.
module tb_display_scanner;
  localparam int DIGITS      = 4;
  localparam int SCAN_DIV    = 3;
  localparam int BLINK_SCANS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] codes;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [4:0]  code;
  logic        frame;

  int total = 0;
  int bad   = 0;

  // One record per scan frame: optional input change (applied mid-slot
  // drv_slot) and the hand-derived outputs for digits 3..0 of that frame.
  typedef struct {
    int          drv_slot;
    logic [19:0] codes;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [15:0] exp_an;
    logic [19:0] exp_code;
  } frame_vec_t;

  frame_vec_t vecs [10];

  always #5 clk = ~clk;

  display_scanner #(
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .BLINK_SCANS(BLINK_SCANS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .codes(codes),
    .blank(blank),
    .blink(blink),
    .an(an),
    .code(code),
    .frame(frame)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Display is dark for 12 cycles after release; frame pulses on the 12th.
  task automatic check_dark_lead(input string tag);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk({tag, "_an"}, 32'(an), 32'hF);
      chk({tag, "_code"}, 32'(code), 32'h0);
      chk({tag, "_frame"}, 32'(frame), 32'(i == 12));
    end
    $display("%s: dark lead-in checked", tag);
  endtask

  initial begin
    logic [15:0] plain_an;
    logic [19:0] c4321, c9, cmix;
    bit found;
    plain_an = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    c4321    = {5'd4, 5'd3, 5'd2, 5'd1};
    c9       = {5'd9, 5'd9, 5'd9, 5'd9};
    cmix     = {5'h1F, 5'd7, 5'd6, 5'd5};

    vecs[0] = '{-1, c4321, 4'b0000, 4'b0000, plain_an, c4321};
    vecs[1] = '{1,  c9,    4'b0000, 4'b0000, plain_an, c4321};
    vecs[2] = '{0,  c9,    4'b0100, 4'b0010, plain_an, c9};
    vecs[3] = '{-1, c9,    4'b0100, 4'b0010, {4'b0111, 4'b1111, 4'b1101, 4'b1110}, c9};
    vecs[4] = '{-1, c9,    4'b0100, 4'b0010, {4'b0111, 4'b1111, 4'b1101, 4'b1110}, c9};
    vecs[5] = '{-1, c9,    4'b0100, 4'b0010, {4'b0111, 4'b1111, 4'b1111, 4'b1110}, c9};
    vecs[6] = '{0,  cmix,  4'b0010, 4'b0010, {4'b0111, 4'b1111, 4'b1111, 4'b1110}, c9};
    vecs[7] = '{-1, cmix,  4'b0010, 4'b0010, {4'b0111, 4'b1011, 4'b1111, 4'b1110}, cmix};
    vecs[8] = '{-1, cmix,  4'b0010, 4'b0010, {4'b0111, 4'b1011, 4'b1111, 4'b1110}, cmix};
    vecs[9] = '{-1, cmix,  4'b0010, 4'b0010, {4'b0111, 4'b1011, 4'b1111, 4'b1110}, cmix};

    rst   = 1'b0;
    codes = c4321;
    blank = 4'b0000;
    blink = 4'b0000;
    #1 rst = 1'b1;
    #1;
    chk("rst_async_an", 32'(an), 32'hF);
    chk("rst_async_code", 32'(code), 32'h0);
    chk("rst_async_frame", 32'(frame), 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_hold_an", 32'(an), 32'hF);
    chk("rst_hold_code", 32'(code), 32'h0);
    chk("rst_hold_frame", 32'(frame), 32'h0);
    $display("reset: outputs checked while rst=1");
    rst = 1'b0;

    check_dark_lead("powerup");

    for (int f = 0; f < 10; f++) begin
      for (int d = 0; d < 4; d++) begin
        for (int s = 0; s < 3; s++) begin
          if (vecs[f].drv_slot == d && s == 1) begin
            codes = vecs[f].codes;
            blank = vecs[f].blank;
            blink = vecs[f].blink;
          end
          @(negedge clk);
          chk($sformatf("f%0d_d%0d_s%0d_an", f, d, s), 32'(an), 32'(vecs[f].exp_an[4*d +: 4]));
          chk($sformatf("f%0d_d%0d_s%0d_code", f, d, s), 32'(code), 32'(vecs[f].exp_code[5*d +: 5]));
          chk($sformatf("f%0d_d%0d_s%0d_frame", f, d, s), 32'(frame), 32'(d == 3 && s == 2));
        end
      end
      $display("frame %0d: an/code/frame checked", f);
    end

    found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1011) found = 1'b1;
    end
    chk("wait_digit2", 32'(found), 32'h1);
    if (found) begin
      #2 rst = 1'b1;
      #1;
      chk("midrst_an", 32'(an), 32'hF);
      chk("midrst_code", 32'(code), 32'h0);
      chk("midrst_frame", 32'(frame), 32'h0);
      @(negedge clk);
      codes = c4321;
      blank = 4'b0000;
      blink = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      check_dark_lead("midrst");
      for (int s = 0; s < 6; s++) begin
        @(negedge clk);
        chk("midrst_restart_an", 32'(an), (s < 3) ? 32'hE : 32'hD);
        chk("midrst_restart_code", 32'(code), (s < 3) ? 32'd1 : 32'd2);
        chk("midrst_restart_frame", 32'(frame), 32'h0);
      end
      $display("mid-frame reset: restart at digit 0 checked");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
